// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the immediate encoder and the decode side.
//   INSTRUCT_WIDTH / DATA_WIDTH / ERR_CNT_WIDTH : default widths
//   immsrc_e                                    : immediate type coding (I/S/B/J)
//   fits_signed()                               : range helper for the encoder
package imm_pkg;

    localparam int INSTRUCT_WIDTH = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int ERR_CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_e;

    // A value fits in a bits-wide signed field exactly when everything from
    // bit (bits-1) upward is a copy of the sign, i.e. the arithmetic shift
    // leaves all zeros or all ones.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request/response bundle of the immediate encoder.
//   in_valid/in_ready   : request handshake, with in_instr, in_imm, in_immsrc
//   out_valid/out_ready : result handshake, with out_instr, out_err
//   err_count           : saturating count of delivered errored results
//   slave  modport : the encoder side
//   master modport : the producer/consumer side
interface imm_encoder_if #(
    parameter int INSTRUCT_WIDTH = imm_pkg::INSTRUCT_WIDTH,
    parameter int DATA_WIDTH     = imm_pkg::DATA_WIDTH,
    parameter int ERR_CNT_WIDTH  = imm_pkg::ERR_CNT_WIDTH
);
    logic                      in_valid;
    logic                      in_ready;
    logic [INSTRUCT_WIDTH-1:0] in_instr;
    logic [DATA_WIDTH-1:0]     in_imm;
    logic [1:0]                in_immsrc;
    logic                      out_valid;
    logic                      out_ready;
    logic [INSTRUCT_WIDTH-1:0] out_instr;
    logic                      out_err;
    logic [ERR_CNT_WIDTH-1:0]  err_count;

    modport slave (
        input  in_valid, in_instr, in_imm, in_immsrc, out_ready,
        output in_ready, out_valid, out_instr, out_err, err_count
    );

    modport master (
        output in_valid, in_instr, in_imm, in_immsrc, out_ready,
        input  in_ready, out_valid, out_instr, out_err, err_count
    );
endinterface

// File: rtl/imm_field_pack.sv
// imm_field_pack: combinational scatter of an immediate into the RISC-V
// I/S/B/J fields of an instruction word, plus the representability check.
//   base_instr : instruction whose non-immediate bits pass through
//   imm        : signed immediate (byte offset for B/J)
//   immsrc     : immediate type
//   pack_instr : base_instr with the immediate fields overwritten
//   err        : immediate does not fit the selected type
module imm_field_pack
    import imm_pkg::*;
(
    input  logic [31:0] base_instr,
    input  logic [31:0] imm,
    input  immsrc_e     immsrc,
    output logic [31:0] pack_instr,
    output logic        err
);

    // Start from the base word and overwrite only the fields owned by the
    // selected type. Fields are always written with the truncated immediate,
    // even when err is raised, so a bad offset is still visible downstream.
    // B and J drop imm[0] from the encoding, so an odd offset is an error.
    always_comb begin
        pack_instr = base_instr;
        err        = 1'b0;
        case (immsrc)
            IMM_I: begin
                pack_instr[31:20] = imm[11:0];
                err               = !fits_signed(imm, 12);
            end
            IMM_S: begin
                pack_instr[31:25] = imm[11:5];
                pack_instr[11:7]  = imm[4:0];
                err               = !fits_signed(imm, 12);
            end
            IMM_B: begin
                pack_instr[31]    = imm[12];
                pack_instr[7]     = imm[11];
                pack_instr[30:25] = imm[10:5];
                pack_instr[11:8]  = imm[4:1];
                err               = !fits_signed(imm, 13) || imm[0];
            end
            IMM_J: begin
                pack_instr[31]    = imm[20];
                pack_instr[19:12] = imm[19:12];
                pack_instr[20]    = imm[11];
                pack_instr[30:21] = imm[10:1];
                err               = !fits_signed(imm, 21) || imm[0];
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined immediate encoder with valid/ready
// handshakes on both sides and a saturating error counter.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : imm_encoder_if slave (request in, encoded result out, err_count)
module imm_encoder
    import imm_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    imm_encoder_if.slave  bus
);

    logic                      s1_valid;
    logic [INSTRUCT_WIDTH-1:0] s1_instr;
    logic [DATA_WIDTH-1:0]     s1_imm;
    immsrc_e                   s1_src;

    logic                      s2_valid;
    logic [INSTRUCT_WIDTH-1:0] s2_instr;
    logic                      s2_err;

    logic [ERR_CNT_WIDTH-1:0]  err_cnt;

    logic                      s1_adv;
    logic                      s2_adv;
    logic [INSTRUCT_WIDTH-1:0] pack_instr;
    logic                      pack_err;

    // Each stage may move when it is empty or the stage after it is moving,
    // so a full pipe still streams one item per cycle and in_ready never
    // looks at in_valid.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    assign bus.out_valid = s2_valid;
    assign bus.out_instr = s2_instr;
    assign bus.out_err   = s2_err;
    assign bus.err_count = err_cnt;

    imm_field_pack u_pack (
        .base_instr (s1_instr),
        .imm        (s1_imm),
        .immsrc     (s1_src),
        .pack_instr (pack_instr),
        .err        (pack_err)
    );

    // Stage 1 captures the raw request. Data only loads on a real transfer
    // so an idle bus does not disturb a held request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_imm   <= '0;
            s1_src   <= IMM_I;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_instr <= bus.in_instr;
                s1_imm   <= bus.in_imm;
                s1_src   <= immsrc_e'(bus.in_immsrc);
            end
        end
    end

    // Stage 2 holds the encoded word and its error flag together so they
    // always leave the block in the same cycle and stay frozen under stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= pack_instr;
                s2_err   <= pack_err;
            end
        end
    end

    // Count errored results as they are actually handed over, sticking at
    // the all-ones value instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (s2_valid && bus.out_ready && s2_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: scoreboard bench for imm_encoder. The driver pushes the
// reference result of every accepted request into a queue; a monitor pops
// and compares whenever a result is handed over.
module tb_imm_encoder;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [31:0] imm;
        logic [1:0]  src;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    imm_encoder_if bus ();

    imm_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t expQ[$];
    int   deliverCycles[$];
    int   cycleCount = 0;
    int   modelErrCount = 0;
    bit   randReady = 1'b0;
    bit   holdReady = 1'b1;

    // Comparison helper shared by driver and monitor.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Which immediate bit lands on instruction bit p for a given type, or -1
    // when that bit belongs to the base instruction.
    function automatic int immBitFor(input logic [1:0] src, input int p);
        case (src)
            2'b00: return (p >= 20) ? p - 20 : -1;
            2'b01: begin
                if (p >= 25) return p - 20;
                if (p >= 7 && p <= 11) return p - 7;
                return -1;
            end
            2'b10: begin
                if (p == 31) return 12;
                if (p == 7) return 11;
                if (p >= 25 && p <= 30) return p - 20;
                if (p >= 8 && p <= 11) return p - 7;
                return -1;
            end
            default: begin
                if (p == 31) return 20;
                if (p == 20) return 11;
                if (p >= 12 && p <= 19) return p;
                if (p >= 21 && p <= 30) return p - 20;
                return -1;
            end
        endcase
    endfunction

    function automatic logic [31:0] modelInstr(input logic [31:0] base, input logic [31:0] imm, input logic [1:0] src);
        logic [31:0] r;
        int b;
        r = base;
        for (int p = 0; p < 32; p++) begin
            b = immBitFor(src, p);
            if (b >= 0) r[p] = imm[b];
        end
        return r;
    endfunction

    // Representable ranges as plain signed arithmetic.
    function automatic logic modelErr(input logic [31:0] imm, input logic [1:0] src);
        int s;
        s = $signed(imm);
        case (src)
            2'b00, 2'b01: return !(s >= -2048 && s <= 2047);
            2'b10:        return !(s >= -4096 && s <= 4095) || imm[0];
            default:      return !(s >= -1048576 && s <= 1048575) || imm[0];
        endcase
    endfunction

    // Standard decode-side sign extension of each immediate format.
    function automatic logic [31:0] decodeImm(input logic [31:0] i, input logic [1:0] src);
        case (src)
            2'b00:   return {{20{i[31]}}, i[31:20]};
            2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
            2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    // Offer one request for up to maxCycles cycles. Inputs change only on the
    // falling edge; in_ready is read just after so the outcome of the next
    // rising edge is known. useExp selects a fixed expected word.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] imm, input logic [1:0] src,
                                 input int maxCycles, input bit useExp, input logic [31:0] expInstr,
                                 input logic expErr, output bit accepted);
        exp_t e;
        accepted = 1'b0;
        for (int c = 0; c < maxCycles && !accepted; c++) begin
            @(negedge clk);
            bus.out_ready = randReady ? ($urandom_range(0, 3) != 0) : holdReady;
            bus.in_valid  = 1'b1;
            bus.in_instr  = instr;
            bus.in_imm    = imm;
            bus.in_immsrc = src;
            #1;
            if (bus.in_ready) begin
                accepted = 1'b1;
                e.instr  = useExp ? expInstr : modelInstr(instr, imm, src);
                e.err    = useExp ? expErr : modelErr(imm, src);
                e.imm    = imm;
                e.src    = src;
                expQ.push_back(e);
            end
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = holdReady;
        end
    endtask

    task automatic waitDrain(input int bound);
        for (int c = 0; c < bound && expQ.size() != 0; c++) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
    endtask

    // Monitor: samples mid low phase, after the driver has settled.
    initial begin : monitor
        bit          prevHeld;
        logic [31:0] heldInstr;
        logic        heldErr;
        exp_t        e;
        prevHeld = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            cycleCount++;
            if (!rst_n) begin
                prevHeld = 1'b0;
                continue;
            end
            checkOutput("err_count", 64'(bus.err_count), 64'(modelErrCount));
            if (prevHeld && bus.out_valid) begin
                checkOutput("hold_instr", 64'(bus.out_instr), 64'(heldInstr));
                checkOutput("hold_err", 64'(bus.out_err), 64'(heldErr));
            end
            prevHeld  = bus.out_valid && !bus.out_ready;
            heldInstr = bus.out_instr;
            heldErr   = bus.out_err;
            if (bus.out_valid && bus.out_ready) begin
                deliverCycles.push_back(cycleCount);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 64'(bus.out_instr), 64'd0);
                    checkOutput("unexpected_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_instr", 64'(bus.out_instr), 64'(e.instr));
                    checkOutput("out_err", 64'(bus.out_err), 64'(e.err));
                    if (!e.err)
                        checkOutput("round_trip", 64'(decodeImm(bus.out_instr, e.src)), 64'(e.imm));
                    if (e.err && modelErrCount < 255) modelErrCount++;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : driver
        bit          acc;
        int          nAcc;
        logic [31:0] capInstr;
        logic        capErr;
        logic [31:0] rImm;
        logic [1:0]  rSrc;
        int          mode;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_imm = '0; bus.in_immsrc = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_instr", 64'(bus.out_instr), 64'd0);
        checkOutput("rst_out_err", 64'(bus.out_err), 64'd0);
        checkOutput("rst_err_count", 64'(bus.err_count), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed I-type.
        holdReady = 1'b1;
        applyStimulus(32'h0000_0093, 32'hFFFF_FFFF, 2'b00, 1, 1'b1, 32'hFFF0_0093, 1'b0, acc);
        checkOutput("i_accept", 64'(acc), 64'd1);
        waitDrain(20);

        // S, B, J back to back; results must come out on consecutive cycles.
        deliverCycles.delete();
        applyStimulus(32'h0000_2023, 32'd8, 2'b01, 1, 1'b1, 32'h0000_2423, 1'b0, acc);
        checkOutput("s_accept", 64'(acc), 64'd1);
        applyStimulus(32'h0000_0063, 32'hFFFF_FFFC, 2'b10, 1, 1'b1, 32'hFE00_0EE3, 1'b0, acc);
        checkOutput("b_accept", 64'(acc), 64'd1);
        applyStimulus(32'h0000_006F, 32'd2048, 2'b11, 1, 1'b1, 32'h0010_006F, 1'b0, acc);
        checkOutput("j_accept", 64'(acc), 64'd1);
        waitDrain(20);
        checkOutput("sbj_count", 64'(deliverCycles.size()), 64'd3);
        if (deliverCycles.size() == 3) begin
            checkOutput("sbj_gap1", 64'(deliverCycles[1] - deliverCycles[0]), 64'd1);
            checkOutput("sbj_gap2", 64'(deliverCycles[2] - deliverCycles[1]), 64'd1);
        end

        // Range errors.
        applyStimulus(32'h0000_0093, 32'd2048, 2'b00, 5, 1'b1, 32'h8000_0093, 1'b1, acc);
        waitDrain(20);
        checkOutput("err_count_one", 64'(bus.err_count), 64'd1);
        applyStimulus(32'h0000_0063, 32'd6, 2'b10, 5, 1'b1, 32'h0000_0363, 1'b0, acc);
        applyStimulus(32'h0000_0063, 32'd5, 2'b10, 5, 1'b1, 32'h0000_0263, 1'b1, acc);
        waitDrain(20);
        checkOutput("err_count_two", 64'(bus.err_count), 64'd2);

        // Backpressure: four single-cycle offers into a stalled pipe.
        holdReady = 1'b0;
        nAcc = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'h0000_0013 | (32'(k) << 7), 32'(k * 4 + 1), 2'b00, 1, 1'b0, '0, 1'b0, acc);
            if (acc) nAcc++;
        end
        checkOutput("bp_accepted", 64'(nAcc), 64'd2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("bp_out_valid", 64'(bus.out_valid), 64'd1);
        capInstr = bus.out_instr;
        capErr   = bus.out_err;
        idleCycles(3);
        #1;
        checkOutput("bp_stable_instr", 64'(bus.out_instr), 64'(capInstr));
        checkOutput("bp_stable_err", 64'(bus.out_err), 64'(capErr));
        holdReady = 1'b1;
        waitDrain(20);

        // Reset with both stages full.
        holdReady = 1'b0;
        applyStimulus(32'h0000_0093, 32'd3000, 2'b00, 1, 1'b0, '0, 1'b0, acc);
        applyStimulus(32'h0000_0093, 32'd7, 2'b00, 1, 1'b0, '0, 1'b0, acc);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expQ.delete();
        modelErrCount = 0;
        #1;
        checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_rst_out_instr", 64'(bus.out_instr), 64'd0);
        checkOutput("mid_rst_err_count", 64'(bus.err_count), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        holdReady = 1'b1;
        idleCycles(5);

        // Randomized round trip with random output stalls.
        randReady = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            rSrc = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 3);
            case (mode)
                0:       rImm = $urandom;
                1:       rImm = 32'(int'($urandom_range(0, 16383)) - 8192);
                2:       rImm = 32'(int'($urandom_range(0, 4194303)) - 2097152);
                default: rImm = 32'(int'($urandom_range(0, 8191)) - 4096);
            endcase
            if ($urandom_range(0, 1) == 1) rImm[0] = 1'b0;
            applyStimulus($urandom, rImm, rSrc, 100, 1'b0, '0, 1'b0, acc);
            if (!acc) checkOutput("rand_accept_timeout", 64'(acc), 64'd1);
        end
        randReady = 1'b0;
        waitDrain(100);

        // Saturation from a fresh count.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expQ.delete();
        modelErrCount = 0;
        holdReady = 1'b1;
        for (int n = 0; n < 300; n++) begin
            applyStimulus(32'h0000_0093, 32'd2048, 2'b00, 10, 1'b0, '0, 1'b0, acc);
        end
        waitDrain(50);
        checkOutput("err_count_sat", 64'(bus.err_count), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
